// File: rtl/tm1638_key_reader_if.sv
// TM1638 key reader bus: request/status handshake plus the raw
// STB/CLK/DIO pin signals toward the display controller.
interface tm1638_key_reader_if;
  logic       start;
  logic       dio_in;
  logic       stb;
  logic       clk_kHz;
  logic       dio_out;
  logic       dio_oe;
  logic [7:0] keys;
  logic       keys_valid;
  logic       busy;

  modport master (
    output start, dio_in,
    input  stb, clk_kHz, dio_out, dio_oe,
    input  keys, keys_valid, busy
  );

  modport slave (
    input  start, dio_in,
    output stb, clk_kHz, dio_out, dio_oe,
    output keys, keys_valid, busy
  );
endinterface

// File: rtl/tm1638_key_reader.sv
// TM1638 key scanner: sends the read-keys command (0x42), reads the
// four scan bytes and publishes the eight S1..S8 key states.
module tm1638_key_reader #(
  parameter int CLK_DIV = 50,
  parameter int T_WAIT  = 200
) (
  input logic             clk,
  input logic             rst,
  tm1638_key_reader_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, STB_SETUP, CMD, WAIT, READ, STB_END
  } state_t;

  localparam int MAXC = (2*CLK_DIV > T_WAIT) ? 2*CLK_DIV : T_WAIT;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] HALF_M1 = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(2*CLK_DIV - 1);
  localparam logic [CW-1:0] WAIT_M1 = CW'(T_WAIT - 1);
  localparam logic [7:0]    CMD_BYTE = 8'h42;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [4:0]    bit_q;
  logic          cnt_last;
  logic [7:0]    keys_sh;
  logic [7:0]    keys_q;
  logic          valid_q;

  // terminal count of the cycle counter for the current state
  always_comb begin
    cnt_last = 1'b0;
    unique case (state_q)
      STB_SETUP, STB_END: cnt_last = (cnt_q == HALF_M1);
      CMD, READ:          cnt_last = (cnt_q == FULL_M1);
      WAIT:               cnt_last = (cnt_q == WAIT_M1);
      default:            cnt_last = 1'b0;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // next-state: phases advance on counter/bit terminal counts
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (bus.start) state_d = STB_SETUP;
      STB_SETUP:
        if (cnt_last) state_d = CMD;
      CMD:
        if (cnt_last && bit_q == 5'd7) state_d = WAIT;
      WAIT:
        if (cnt_last) state_d = READ;
      READ:
        if (cnt_last && bit_q == 5'd31) state_d = STB_END;
      STB_END:
        if (cnt_last) state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  // cycle and bit counters, cleared whenever the phase changes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      bit_q <= '0;
    end else if (state_q == IDLE) begin
      cnt_q <= '0;
      bit_q <= '0;
    end else begin
      cnt_q <= cnt_last ? '0 : cnt_q + 1'b1;
      if ((state_q == CMD || state_q == READ) && cnt_last)
        bit_q <= (state_d != state_q) ? 5'd0 : bit_q + 5'd1;
    end
  end

  // capture key bits on the serial-clock rise; publish at end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      keys_sh <= '0;
      keys_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (state_q == IDLE && bus.start)
        keys_sh <= '0;
      if (state_q == READ && cnt_q == HALF_M1) begin
        if (bit_q[2:0] == 3'd0)
          keys_sh[{1'b0, bit_q[4:3]}] <= bus.dio_in;
        else if (bit_q[2:0] == 3'd4)
          keys_sh[{1'b1, bit_q[4:3]}] <= bus.dio_in;
      end
      if (state_q == STB_END && cnt_last) begin
        keys_q  <= keys_sh;
        valid_q <= 1'b1;
      end
    end
  end

  // pin and status outputs decoded from the phase
  always_comb begin
    bus.stb        = 1'b1;
    bus.clk_kHz    = 1'b1;
    bus.dio_out    = 1'b1;
    bus.dio_oe     = 1'b0;
    bus.busy       = (state_q != IDLE);
    bus.keys       = keys_q;
    bus.keys_valid = valid_q;
    unique case (state_q)
      STB_SETUP: begin
        bus.stb     = 1'b0;
        bus.dio_oe  = 1'b1;
        bus.dio_out = 1'b0;
      end
      CMD: begin
        bus.stb     = 1'b0;
        bus.dio_oe  = 1'b1;
        bus.clk_kHz = (cnt_q > HALF_M1);
        bus.dio_out = CMD_BYTE[bit_q[2:0]];
      end
      WAIT, STB_END: begin
        bus.stb = 1'b0;
      end
      READ: begin
        bus.stb     = 1'b0;
        bus.clk_kHz = (cnt_q > HALF_M1);
      end
      default: ;
    endcase
  end

endmodule
